sayeh_cpu: RTL and testbench

`sayeh_cpu` is a 16-bit multi-cycle CPU core for the SAYEH (Simple Architecture Yet Enough Hardware) architecture. It fetches and executes 8-bit short and 16-bit long instructions from a shared word-addressed memory/IO bus. The register file is windowed, and the core keeps carry and zero flags. It is the top-level processor block and connects directly to the system RAM and IO ports.

---
 rtl/sayeh_pkg.sv | 54 +++++
 rtl/sayeh_regfile.sv | 29 ++
 rtl/sayeh_cpu.sv | 148 ++++++++++++++
 tb/tb_sayeh_cpu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sayeh_pkg.sv
// Shared encodings for the SAYEH core: opcodes, sub-opcodes, FSM states and helpers.
package sayeh_pkg;

  typedef enum logic [2:0] {FETCH, EXEC_HI, EXEC_LO, MEM, HALT} stateT;
  typedef enum logic [1:0] {MEM_LDA, MEM_STA, MEM_INP, MEM_OUP} memKindT;

  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_MVR  = 4'h1;
  localparam logic [3:0] OP_LDA  = 4'h2;
  localparam logic [3:0] OP_STA  = 4'h3;
  localparam logic [3:0] OP_INP  = 4'h4;
  localparam logic [3:0] OP_OUP  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_ORR  = 4'h7;
  localparam logic [3:0] OP_NOT  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_ADD  = 4'hB;
  localparam logic [3:0] OP_SUB  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_LONG = 4'hF;

  localparam logic [3:0] SYS_NOP = 4'h0;
  localparam logic [3:0] SYS_HLT = 4'h1;
  localparam logic [3:0] SYS_SZF = 4'h2;
  localparam logic [3:0] SYS_CZF = 4'h3;
  localparam logic [3:0] SYS_SCF = 4'h4;
  localparam logic [3:0] SYS_CCF = 4'h5;
  localparam logic [3:0] SYS_CWP = 4'h6;
  localparam logic [3:0] SYS_JPR = 4'h7;
  localparam logic [3:0] SYS_BRZ = 4'h8;
  localparam logic [3:0] SYS_BRC = 4'h9;
  localparam logic [3:0] SYS_AWP = 4'hA;

  localparam logic [1:0] LNG_MIL = 2'd0;
  localparam logic [1:0] LNG_MIH = 2'd1;
  localparam logic [1:0] LNG_SPC = 2'd2;
  localparam logic [1:0] LNG_JPA = 2'd3;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  // A long instruction owns the whole word; its lower byte is the immediate.
  function automatic logic isLong(input logic [7:0] b);
    return (b[7:4] == OP_LONG) ||
           (b[7:4] == OP_SYS && b[3:0] >= SYS_JPR && b[3:0] <= SYS_AWP);
  endfunction

endpackage

// File: rtl/sayeh_regfile.sv
// 64x16 windowed register file: operands are addressed relative to the window pointer.
module sayeh_regfile (
  input  logic        clk,
  input  logic [5:0]  wp,
  input  logic [1:0]  dSel,
  input  logic [1:0]  sSel,
  input  logic        writeEn,
  input  logic [15:0] writeData,
  output logic [15:0] rdData,
  output logic [15:0] rsData
);

  logic [15:0] regs [64];
  logic [5:0]  dAddr;
  logic [5:0]  sAddr;

  // 6-bit sums wrap mod 64 by construction.
  assign dAddr = wp + {4'b0000, dSel};
  assign sAddr = wp + {4'b0000, sSel};

  // NOTE: the array has no reset, so it maps onto plain RAM without per-word reset muxes.
  always_ff @(posedge clk) begin
    if (writeEn) regs[dAddr] <= writeData;
  end

  assign rdData = regs[dAddr];
  assign rsData = regs[sAddr];

endmodule

// File: rtl/sayeh_cpu.sv
// SAYEH multi-cycle core: fetch/execute FSM, inline ALU and shared memory/IO bus.
module sayeh_cpu import sayeh_pkg::*; (
  input  logic        clk,
  input  logic        ExternalReset,
  output logic        ReadMem,
  output logic        WriteMem,
  output logic        ReadIO,
  output logic        WriteIO,
  inout  wire  [15:0] Databus,
  output logic [15:0] Addressbus,
  input  logic        MemDataready
);

  stateT       state, memNext, afterExec;
  memKindT     memKind, memKindNext;
  logic [15:0] pc, ir, memAddr, memData, pcInstr, rdData, rsData;
  logic [5:0]  wp, nextWp;
  logic [1:0]  flags, memD, dSel;
  logic [7:0]  curByte, imm;
  logic [3:0]  op;
  logic [15:0] rfWdata, aluRes, jumpTarget;
  logic [16:0] wide;
  logic        rfWe, setZ, newC, newZ, jumpTaken, doHalt, isMemOp, inExec;

  assign inExec  = (state == EXEC_HI) || (state == EXEC_LO);
  assign curByte = (state == EXEC_LO) ? ir[7:0] : ir[15:8];
  assign op      = curByte[7:4];
  assign imm     = ir[7:0];
  assign pcInstr = pc - 16'd1;
  assign dSel    = (state == MEM) ? memD : curByte[3:2];

  assign afterExec = (state == EXEC_HI && !isLong(ir[15:8]) && ir[7:0] != 8'h00) ? EXEC_LO : FETCH;

  sayeh_regfile u_regfile (
    .clk      (clk),
    .wp       (wp),
    .dSel     (dSel),
    .sSel     (curByte[1:0]),
    .writeEn  (rfWe),
    .writeData(rfWdata),
    .rdData   (rdData),
    .rsData   (rsData)
  );

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    rfWe = 1'b0; rfWdata = '0; aluRes = '0; wide = '0; setZ = 1'b0;
    newC = flags[FLAG_C]; newZ = flags[FLAG_Z]; nextWp = wp;
    jumpTaken = 1'b0; jumpTarget = pcInstr + sext8(imm);
    doHalt = 1'b0; isMemOp = 1'b0; memKindNext = MEM_LDA;
    if (state == MEM) begin
      rfWe    = MemDataready && (memKind == MEM_LDA || memKind == MEM_INP);
      rfWdata = Databus;
    end else if (inExec) begin
      case (op)
        OP_SYS: case (curByte[3:0])
          SYS_HLT: doHalt = 1'b1;
          SYS_SZF: newZ = 1'b1;
          SYS_CZF: newZ = 1'b0;
          SYS_SCF: newC = 1'b1;
          SYS_CCF: newC = 1'b0;
          SYS_CWP: nextWp = '0;
          SYS_JPR: jumpTaken = (state == EXEC_HI);
          SYS_BRZ: jumpTaken = (state == EXEC_HI) && flags[FLAG_Z];
          SYS_BRC: jumpTaken = (state == EXEC_HI) && flags[FLAG_C];
          SYS_AWP: if (state == EXEC_HI) nextWp = wp + imm[5:0];
          default: ;
        endcase
        OP_MVR: begin rfWe = 1'b1; rfWdata = rsData; end
        OP_LDA: begin isMemOp = 1'b1; memKindNext = MEM_LDA; end
        OP_STA: begin isMemOp = 1'b1; memKindNext = MEM_STA; end
        OP_INP: begin isMemOp = 1'b1; memKindNext = MEM_INP; end
        OP_OUP: begin isMemOp = 1'b1; memKindNext = MEM_OUP; end
        OP_AND: begin aluRes = rdData & rsData; setZ = 1'b1; end
        OP_ORR: begin aluRes = rdData | rsData; setZ = 1'b1; end
        OP_NOT: begin aluRes = ~rsData; setZ = 1'b1; end
        OP_SHL: begin aluRes = {rsData[14:0], 1'b0}; newC = rsData[15]; setZ = 1'b1; end
        OP_SHR: begin aluRes = {1'b0, rsData[15:1]}; newC = rsData[0]; setZ = 1'b1; end
        OP_ADD: begin
          wide = {1'b0, rdData} + {1'b0, rsData} + {16'b0, flags[FLAG_C]};
          aluRes = wide[15:0]; newC = wide[16]; setZ = 1'b1;
        end
        OP_SUB: begin
          // Bit 16 of the widened difference is the borrow.
          wide = {1'b0, rdData} - {1'b0, rsData} - {16'b0, flags[FLAG_C]};
          aluRes = wide[15:0]; newC = wide[16]; setZ = 1'b1;
        end
        OP_MUL: begin aluRes = {8'h00, rdData[7:0]} * {8'h00, rsData[7:0]}; setZ = 1'b1; end
        OP_CMP: begin newZ = (rdData == rsData); newC = (rdData < rsData); end
        OP_LONG: if (state == EXEC_HI) begin
          case (ir[9:8])
            LNG_MIL: begin rfWe = 1'b1; rfWdata = {8'h00, imm}; end
            LNG_MIH: begin rfWe = 1'b1; rfWdata = {imm, rdData[7:0]}; end
            LNG_SPC: begin rfWe = 1'b1; rfWdata = pcInstr + sext8(imm); end
            default: begin jumpTaken = 1'b1; jumpTarget = rdData + sext8(imm); end
          endcase
        end
        default: ;
      endcase
      if (setZ) begin
        rfWe = 1'b1; rfWdata = aluRes; newZ = (aluRes == 16'h0000);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge ExternalReset) begin
    if (ExternalReset) begin
      state <= FETCH; pc <= '0; ir <= '0; wp <= '0; flags <= '0;
      memKind <= MEM_LDA; memAddr <= '0; memData <= '0; memD <= '0; memNext <= FETCH;
    end else begin
      case (state)
        FETCH: if (MemDataready) begin
          ir <= Databus; pc <= pc + 16'd1; state <= EXEC_HI;
        end
        EXEC_HI, EXEC_LO: begin
          flags[FLAG_C] <= newC;
          flags[FLAG_Z] <= newZ;
          wp <= nextWp;
          if (jumpTaken) pc <= jumpTarget;
          if (doHalt) state <= HALT;
          else if (isMemOp) begin
            memKind <= memKindNext;
            memAddr <= (op == OP_STA || op == OP_OUP) ? rdData : rsData;
            memData <= rsData;
            memD    <= curByte[3:2];
            memNext <= afterExec;
            state   <= MEM;
          end else state <= afterExec;
        end
        MEM: if (memKind == MEM_STA || memKind == MEM_OUP || MemDataready) state <= memNext;
        HALT: ;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes decode the registered state; gating with reset drops them immediately.
  assign ReadMem  = !ExternalReset && (state == FETCH || (state == MEM && memKind == MEM_LDA));
  assign WriteMem = !ExternalReset && state == MEM && memKind == MEM_STA;
  assign ReadIO   = !ExternalReset && state == MEM && memKind == MEM_INP;
  assign WriteIO  = !ExternalReset && state == MEM && memKind == MEM_OUP;
  assign Addressbus = ExternalReset ? 16'h0000 :
                      (state == FETCH) ? pc :
                      (state == MEM)   ? memAddr : 16'h0000;
  assign Databus = (WriteMem || WriteIO) ? memData : 16'bz;

endmodule

// File: tb/tb_sayeh_cpu.sv
// Scoreboarded bench: programs push expected bus writes; a negedge monitor pops and compares.
module tb_sayeh_cpu;

  logic        clk = 1'b0;
  logic        ExternalReset = 1'b1;
  logic        ReadMem, WriteMem, ReadIO, WriteIO, MemDataready;
  wire  [15:0] Databus;
  logic [15:0] Addressbus;

  typedef struct packed {
    logic        isIo;
    logic [15:0] addr;
    logic [15:0] data;
  } busWriteT;

  logic [15:0] mem [256];
  logic [15:0] prog [$];
  busWriteT    sbQ [$];
  int          waitCfg = 0;
  int          waitCnt = 0;
  int          testsRun = 0;
  int          testsFailed = 0;
  string       curTest = "reset";

  sayeh_cpu dut (
    .clk         (clk),
    .ExternalReset(ExternalReset),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .ReadIO      (ReadIO),
    .WriteIO     (WriteIO),
    .Databus     (Databus),
    .Addressbus  (Addressbus),
    .MemDataready(MemDataready)
  );

  always #20 clk = ~clk;

  // Bus responder: memory or IO (port ^ C3C3) data, ready after waitCfg wait cycles.
  assign MemDataready = (ReadMem || ReadIO) && (waitCnt >= waitCfg);
  assign Databus = ReadMem ? mem[Addressbus[7:0]] :
                   ReadIO  ? (Addressbus ^ 16'hC3C3) : 16'bz;

  always @(posedge clk) begin
    if (ExternalReset) waitCnt <= 0;
    else if ((ReadMem || ReadIO) && !MemDataready) waitCnt <= waitCnt + 1;
    else waitCnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s.%s: got %h, expected %h", curTest, name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!ExternalReset && (WriteMem || WriteIO)) begin
      busWriteT e;
      check("one_strobe", $countones({ReadMem, WriteMem, ReadIO, WriteIO}), 1);
      check("write_expected", sbQ.size() != 0, 1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        check("write_kind", WriteIO, e.isIo);
        check("write_addr", Addressbus, e.addr);
        check("write_data", Databus, e.data);
      end
      if (WriteMem) mem[Addressbus[7:0]] = Databus;
    end
  end

  task automatic loadProg();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    foreach (prog[i]) mem[i] = prog[i];
  endtask

  task automatic expectWrite(input logic isIo, input logic [15:0] a, input logic [15:0] d);
    sbQ.push_back({isIo, a, d});
  endtask

  task automatic doReset();
    @(negedge clk);
    ExternalReset = 1'b1;
    #1;
    check("rst_strobes", {28'b0, ReadMem, WriteMem, ReadIO, WriteIO}, 0);
    check("rst_addr", Addressbus, 0);
    @(negedge clk);
    ExternalReset = 1'b0;
  endtask

  task automatic runToHalt(input int budget);
    int idle = 0;
    bit halted = 1'b0;
    for (int c = 0; c < budget && !halted; c++) begin
      @(negedge clk);
      if (ReadMem || WriteMem || ReadIO || WriteIO) idle = 0;
      else idle++;
      if (idle >= 6) halted = 1'b1;
    end
    check("halted", halted, 1);
    check("sb_drained", sbQ.size(), 0);
    sbQ.delete();
  endtask

  initial begin
    int cnt;

    // Add and store, entered straight from power-on reset.
    prog = {16'hF005, 16'hF403, 16'hB100, 16'hF880, 16'h3801};
    loadProg();
    expectWrite(1'b0, 16'h0080, 16'h0008);
    #10;
    check("rst_strobes", {28'b0, ReadMem, WriteMem, ReadIO, WriteIO}, 0);
    check("rst_addr", Addressbus, 0);
    check("rst_databus_z", Databus === 16'bz, 1);
    #71 ExternalReset = 1'b0;
    #9;
    check("first_fetch_read", ReadMem, 1);
    check("first_fetch_addr", Addressbus, 0);
    curTest = "add_store";
    runToHalt(200);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ReadMem) cnt++;
    end
    check("no_read_after_halt", cnt, 0);

    curTest = "load_carry";
    prog = {16'hF010, 16'h2400, 16'hF801, 16'hB600, 16'hF8A0, 16'h3900, 16'h0802,
            16'h0001, 16'h0902, 16'h0001, 16'hF4C1, 16'hF8A1, 16'h3901};
    loadProg();
    mem[16'h10] = 16'hFFFF;
    expectWrite(1'b0, 16'h00A0, 16'h0000);
    expectWrite(1'b0, 16'h00A1, 16'h00C1);
    doReset();
    runToHalt(300);

    curTest = "branches";
    prog = {16'hF033, 16'hF433, 16'hE100, 16'h0802, 16'hF0EE, 16'h0902,
            16'hF8B0, 16'h3801};
    loadProg();
    expectWrite(1'b0, 16'h00B0, 16'h0033);
    doReset();
    runToHalt(300);

    curTest = "alu_io";
    prog = {16'hFC40, 16'hF0F0, 16'hF4A5, 16'hF55A, 16'h715C, 16'hD15C, 16'h915C,
            16'hA15C, 16'hC15C, 16'hB15C, 16'h895E, 16'h435C, 16'hF2FE, 16'h5C01};
    loadProg();
    expectWrite(1'b1, 16'h0040, 16'h5AF5);
    expectWrite(1'b1, 16'h0040, 16'h9DE9);
    expectWrite(1'b1, 16'h0040, 16'hB54A);
    expectWrite(1'b1, 16'h0040, 16'h2D52);
    expectWrite(1'b1, 16'h0040, 16'hD2AC);
    expectWrite(1'b1, 16'h0040, 16'h2D52);
    expectWrite(1'b1, 16'h0040, 16'hA55A);
    expectWrite(1'b1, 16'h0040, 16'hC383);
    expectWrite(1'b1, 16'h0040, 16'h000A);
    doReset();
    runToHalt(400);

    curTest = "flags_jpa";
    prog = {16'hFC41, 16'hF00F, 16'hF4F3, 16'h615C, 16'h175D, 16'hE4E1, 16'h0902,
            16'h0001, 16'h0802, 16'h0205, 16'h0802, 16'h0001, 16'h0902, 16'h0403,
            16'h0902, 16'h0001, 16'hF311, 16'h0001, 16'h0001, 16'h0001, 16'h5C01};
    loadProg();
    expectWrite(1'b1, 16'h0041, 16'h0003);
    expectWrite(1'b1, 16'h0041, 16'h0041);
    expectWrite(1'b1, 16'h0041, 16'h0003);
    doReset();
    runToHalt(400);

    curTest = "window";
    prog = {16'h0A03, 16'hF055, 16'h0600, 16'hF490, 16'h3701};
    loadProg();
    expectWrite(1'b0, 16'h0090, 16'h0055);
    doReset();
    runToHalt(200);

    curTest = "window_wrap";
    prog = {16'h0A01, 16'h0A3F, 16'hF066, 16'h0600, 16'hF491, 16'h3401};
    loadProg();
    expectWrite(1'b0, 16'h0091, 16'h0066);
    doReset();
    runToHalt(200);

    curTest = "wait_states";
    prog = {16'hF0AB, 16'hF490, 16'h3401};
    loadProg();
    waitCfg = 3;
    expectWrite(1'b0, 16'h0090, 16'h00AB);
    doReset();
    #1;
    cnt = 0;
    while (ReadMem && Addressbus == 16'h0000 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("fetch_hold_cycles", cnt, 4);
    for (int i = 0; i < 10 && !ReadMem; i++) @(negedge clk);
    check("next_fetch_read", ReadMem, 1);
    check("next_fetch_pc", Addressbus, 16'h0001);
    runToHalt(300);

    curTest = "reset_mid_access";
    doReset();
    @(negedge clk);
    check("pre_reset_read", ReadMem, 1);
    #5 ExternalReset = 1'b1;
    #1;
    check("mid_rst_strobes", {28'b0, ReadMem, WriteMem, ReadIO, WriteIO}, 0);
    check("mid_rst_addr", Addressbus, 0);
    expectWrite(1'b0, 16'h0090, 16'h00AB);
    @(negedge clk);
    ExternalReset = 1'b0;
    runToHalt(300);
    waitCfg = 0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
